// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} dmem_size_t;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} dmem_state_t;

    // Number of bytes moved by an access of the given size (1, 2, 4 or 8).
    function automatic logic [3:0] size_bytes(input dmem_size_t sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic for the data-memory responder: extracts and extends
// load data from a doubleword, and merges store data into a doubleword.
// The offset presented here is the effective lane offset chosen by the top.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [63:0] old_dw_i,
    input  logic [63:0] wdata_i,
    input  dmem_size_t  size_i,
    input  logic [2:0]  offset_i,
    input  logic        unsigned_i,
    output logic [63:0] load_o,
    output logic [63:0] merged_o
);

    logic [63:0] shifted;
    logic [63:0] wshift;
    logic [7:0]  bmask;

    // Load path: move the addressed lane down to bit 0, then zero/sign-extend.
    always_comb begin
        shifted = old_dw_i >> {offset_i, 3'b000};
        load_o  = shifted;
        case (size_i)
            SZ_B:    load_o = unsigned_i ? {56'd0, shifted[7:0]}
                                         : {{56{shifted[7]}}, shifted[7:0]};
            SZ_H:    load_o = unsigned_i ? {48'd0, shifted[15:0]}
                                         : {{48{shifted[15]}}, shifted[15:0]};
            SZ_W:    load_o = unsigned_i ? {32'd0, shifted[31:0]}
                                         : {{32{shifted[31]}}, shifted[31:0]};
            default: load_o = shifted;
        endcase
    end

    // Store path: byte-mask merge of the low store bytes into the selected lanes.
    always_comb begin
        bmask    = 8'((9'd1 << size_bytes(size_i)) - 9'd1) << offset_i;
        wshift   = wdata_i << {offset_i, 3'b000};
        merged_o = old_dw_i;
        for (int i = 0; i < 8; i++) begin
            merged_o[8*i +: 8] = bmask[i] ? wshift[8*i +: 8] : old_dw_i[8*i +: 8];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the multicycle RISC-V core. Serves one load/store
// at a time with a fixed wait latency over valid/ready request/response channels.
// Optional feature: define DMEM_MISALIGN_TRAP_EN to report misaligned accesses
// as errors; otherwise misaligned accesses are aligned down.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_DW = 256,
    parameter int LATENCY  = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W      = $clog2(DEPTH_DW);
    localparam int ADDR_LIM_W = IDX_W + 3;
    localparam int CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    // Control state
    dmem_state_t      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             req_ready_q;
    logic             rsp_valid_q;
    logic [63:0]      rsp_rdata_q;
    logic             rsp_err_q;

    // Captured request (data only, never reset)
    logic             we_q;
    logic             uns_q;
    dmem_size_t       size_q;
    logic [63:0]      addr_q;
    logic [63:0]      wdata_q;

    // Storage: retained across RESET, undefined at power-up
    logic [63:0]      mem_q [DEPTH_DW];

    logic             accept;
    logic             access;
    logic             out_of_range;
    logic             misalign;
    logic             err_d;
    logic             wr_en;
    logic [2:0]       lsb_mask;
    logic [2:0]       offset;
    logic [IDX_W-1:0] idx;
    logic [63:0]      old_dw;
    logic [63:0]      load_dw;
    logic [63:0]      merged_dw;
    logic [63:0]      rdata_d;

    assign accept       = req_ready_q && req_valid;
    assign access       = (state_q == ST_WAIT) && (cnt_q == '0);
    assign out_of_range = (addr_q >> ADDR_LIM_W) != 64'd0;
    assign lsb_mask     = 3'(size_bytes(size_q) - 4'd1);
    assign idx          = addr_q[3 +: IDX_W];
    assign old_dw       = mem_q[idx];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = |(addr_q[2:0] & lsb_mask);
    assign offset   = addr_q[2:0];
`else
    assign misalign = 1'b0;
    assign offset   = addr_q[2:0] & ~lsb_mask;
`endif

    assign err_d   = out_of_range || misalign;
    assign rdata_d = (err_d || we_q) ? 64'd0 : load_dw;
    assign wr_en   = access && we_q && !err_d;

    dmem_lane_align u_align (
        .old_dw_i   (old_dw),
        .wdata_i    (wdata_q),
        .size_i     (size_q),
        .offset_i   (offset),
        .unsigned_i (uns_q),
        .load_o     (load_dw),
        .merged_o   (merged_dw)
    );

    // Capture the request fields on the accepting edge.
    always_ff @(posedge CLK) begin
        if (accept) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            size_q  <= dmem_size_t'(req_size);
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Commit the merged doubleword on the access edge of an in-range store.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[idx] <= merged_dw;
        end
    end

    // Request/response FSM with latency counter and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 64'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q     <= ST_WAIT;
                        req_ready_q <= 1'b0;
                        cnt_q       <= CNT_W'(LATENCY - 1);
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rdata_d;
                        rsp_err_q   <= err_d;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
